// File: rtl/seq_detect_moore_param_if.sv
// Serial pattern-detector bus: stream bits, pattern load and Moore outputs.
// The master drives the stream; the slave (detector) returns match, count and fill.
interface seq_detect_moore_param_if #(
    parameter int PATTERN_W = 4,
    parameter int CNT_W     = 4
);
    localparam int FILL_W = $clog2(PATTERN_W + 1);

    logic                 bit_in;
    logic                 bit_valid;
    logic                 overlap;
    logic [PATTERN_W-1:0] pat_in;
    logic                 pat_load;
    logic                 match;
    logic [CNT_W-1:0]     match_count;
    logic [FILL_W-1:0]    fill;

    modport master (
        output bit_in, bit_valid, overlap, pat_in, pat_load,
        input  match, match_count, fill
    );

    modport slave (
        input  bit_in, bit_valid, overlap, pat_in, pat_load,
        output match, match_count, fill
    );
endinterface

// File: rtl/seq_detect_moore_param.sv
// Moore serial-pattern detector with a loadable pattern and overlap/non-overlap restart.
// Define MATCH_CNT_EN to build the saturating match counter; otherwise match_count is 0.
module seq_detect_moore_param #(
    parameter int                   PATTERN_W   = 4,
    parameter logic [PATTERN_W-1:0] PATTERN_RST = 4'b1011,
    parameter int                   CNT_W       = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    seq_detect_moore_param_if.slave bus
);
    localparam int FILL_W = $clog2(PATTERN_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);

    logic [PATTERN_W-1:0] hist_q, hist_d;
    logic [PATTERN_W-1:0] pat_q,  pat_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic                 match_q, match_d;

    logic [PATTERN_W-1:0] new_hist;
    logic [FILL_W-1:0]    new_fill;
    logic                 hit;

    // Candidate history after accepting the current bit; fill saturates at full
    always_comb begin
        new_hist = {hist_q[PATTERN_W-2:0], bus.bit_in};
        new_fill = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
        hit      = (new_fill == FILL_FULL) && (new_hist == pat_q);
    end

    always_comb begin
        hist_d  = hist_q;
        pat_d   = pat_q;
        fill_d  = fill_q;
        match_d = match_q;
        if (bus.pat_load) begin
            pat_d   = bus.pat_in;
            hist_d  = '0;
            fill_d  = '0;
            match_d = 1'b0;
        end else if (bus.bit_valid) begin
            hist_d  = new_hist;
            match_d = hit;
            fill_d  = (hit && !bus.overlap) ? '0 : new_fill;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q  <= '0;
            pat_q   <= PATTERN_RST;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            pat_q   <= pat_d;
            fill_q  <= fill_d;
            match_q <= match_d;
        end
    end

    assign bus.match = match_q;
    assign bus.fill  = fill_q;

`ifdef MATCH_CNT_EN
    logic [CNT_W-1:0] count_q, count_d;

    // Counter sticks at all-ones instead of wrapping
    always_comb begin
        count_d = count_q;
        if (bus.pat_load) begin
            count_d = '0;
        end else if (bus.bit_valid && hit && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.match_count = count_q;
`else
    assign bus.match_count = {CNT_W{1'b0}};
`endif
endmodule
